// File: rtl/syn_pkg.sv
// rtl/syn_pkg.sv - shared types and constants for the synapse STDP initiator
package syn_pkg;

    localparam int LANE_W = 2;
    localparam int WGT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CALC,
        WR
    } syn_state_t;

endpackage

// File: rtl/syn_stdp_sat_alu.sv
// rtl/syn_stdp_sat_alu.sv - saturating STDP potentiation/depression step
module syn_stdp_sat_alu
    import syn_pkg::*;
#(
    parameter logic [WGT_W-1:0] LTP_STEP = 8'd4,
    parameter logic [WGT_W-1:0] LTD_STEP = 8'd2,
    parameter logic [WGT_W-1:0] W_MAX    = 8'd255,
    parameter logic [WGT_W-1:0] W_MIN    = 8'd0
) (
    input  logic [WGT_W-1:0] w,
    input  logic             ltp,
    output logic [WGT_W-1:0] new_w,
    output logic             sat
);

    logic [WGT_W:0] sum;
    logic [WGT_W:0] floor_lim;

    // One extra bit keeps the overflow/underflow visible; a weight already
    // sitting on the bound it is pushed against counts as clamped.
    always_comb begin
        sum       = {1'b0, w} + {1'b0, LTP_STEP};
        floor_lim = {1'b0, W_MIN} + {1'b0, LTD_STEP};
        new_w     = w;
        sat       = 1'b0;
        if (ltp) begin
            if ((sum > {1'b0, W_MAX}) || (w >= W_MAX)) begin
                new_w = W_MAX;
                sat   = 1'b1;
            end else begin
                new_w = sum[WGT_W-1:0];
            end
        end else begin
            if (({1'b0, w} < floor_lim) || (w <= W_MIN)) begin
                new_w = W_MIN;
                sat   = 1'b1;
            end else begin
                new_w = w - LTD_STEP;
            end
        end
    end

endmodule

// File: rtl/syn_stdp_initiator.sv
// rtl/syn_stdp_initiator.sv - STDP read-modify-write master for one synapse weight memory (option: SYN_STDP_EVBUF_EN)
module syn_stdp_initiator
    import syn_pkg::*;
#(
    parameter int               ADDR_W   = 7,
    parameter int               RD_LAT   = 1,
    parameter logic [WGT_W-1:0] LTP_STEP = 8'd4,
    parameter logic [WGT_W-1:0] LTD_STEP = 8'd2,
    parameter logic [WGT_W-1:0] W_MAX    = 8'd255,
    parameter logic [WGT_W-1:0] W_MIN    = 8'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ev_valid,
    output logic              ev_ready,
    input  logic [ADDR_W-1:0] ev_addr,
    input  logic              ev_ltp,
    output logic [ADDR_W-1:0] syn_addr,
    output logic [31:0]       syn_wdata,
    output logic              syn_w_en,
    output logic              syn_r_en,
    input  logic [WGT_W-1:0]  syn_rdata,
    output logic              done_pulse,
    output logic              sat_flag
);

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    syn_state_t       state;
    logic [2:0]       lat_cnt;
    logic             op_ltp;
    logic [WGT_W-1:0] w_cap;
    logic [WGT_W-1:0] alu_w;
    logic             alu_sat;

    logic              accept;
    logic              launch;
    logic [ADDR_W-1:0] launch_addr;
    logic              launch_ltp;

    assign accept = ev_valid && ev_ready;

`ifdef SYN_STDP_EVBUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_ltp;

    // A held event takes priority; an event accepted straight into IDLE skips the buffer.
    assign ev_ready    = !buf_valid;
    assign launch      = (state == IDLE) && (buf_valid || accept);
    assign launch_addr = buf_valid ? buf_addr : ev_addr;
    assign launch_ltp  = buf_valid ? buf_ltp  : ev_ltp;

    // Park one event while the FSM is busy; release it when IDLE launches it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_ltp   <= 1'b0;
        end else if (accept && (state != IDLE)) begin
            buf_valid <= 1'b1;
            buf_addr  <= ev_addr;
            buf_ltp   <= ev_ltp;
        end else if (launch && buf_valid) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign ev_ready    = (state == IDLE);
    assign launch      = accept;
    assign launch_addr = ev_addr;
    assign launch_ltp  = ev_ltp;
`endif

    syn_stdp_sat_alu #(
        .LTP_STEP (LTP_STEP),
        .LTD_STEP (LTD_STEP),
        .W_MAX    (W_MAX),
        .W_MIN    (W_MIN)
    ) u_alu (
        .w     (w_cap),
        .ltp   (op_ltp),
        .new_w (alu_w),
        .sat   (alu_sat)
    );

    // Read-modify-write sequencer; strobes are registered so each lasts exactly one state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            op_ltp     <= 1'b0;
            w_cap      <= '0;
            syn_addr   <= '0;
            syn_wdata  <= '0;
            syn_r_en   <= 1'b0;
            syn_w_en   <= 1'b0;
            done_pulse <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            syn_r_en   <= 1'b0;
            syn_w_en   <= 1'b0;
            done_pulse <= 1'b0;
            sat_flag   <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state    <= RD_REQ;
                        syn_addr <= launch_addr;
                        op_ltp   <= launch_ltp;
                        syn_r_en <= 1'b1;
                    end
                end
                RD_REQ: begin
                    state   <= RD_WAIT;
                    lat_cnt <= CNT_INIT;
                end
                RD_WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        w_cap <= syn_rdata;
                        state <= CALC;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                CALC: begin
                    syn_wdata  <= {24'b0, alu_w};
                    sat_flag   <= alu_sat;
                    syn_w_en   <= 1'b1;
                    done_pulse <= 1'b1;
                    state      <= WR;
                end
                WR: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syn_stdp_initiator.sv
// tb/tb_syn_stdp_initiator.sv - self-checking bench for syn_stdp_initiator
module tb_syn_stdp_initiator;

    logic        clk;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic [6:0]  ev_addr;
    logic        ev_ltp;
    logic [6:0]  syn_addr;
    logic [31:0] syn_wdata;
    logic        syn_w_en;
    logic        syn_r_en;
    logic [7:0]  syn_rdata;
    logic        done_pulse;
    logic        sat_flag;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem [0:127];

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        sat;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [6:0] addr;
        logic       ltp;
        logic [7:0] w0;
        logic [7:0] exp_w;
        logic       exp_sat;
    } vec_t;

    syn_stdp_initiator dut (
        .clk        (clk),
        .rst        (rst),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_addr    (ev_addr),
        .ev_ltp     (ev_ltp),
        .syn_addr   (syn_addr),
        .syn_wdata  (syn_wdata),
        .syn_w_en   (syn_w_en),
        .syn_r_en   (syn_r_en),
        .syn_rdata  (syn_rdata),
        .done_pulse (done_pulse),
        .sat_flag   (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Synapse model, read latency 1
    always @(posedge clk) begin
        if (syn_r_en) syn_rdata <= mem[syn_addr];
        if (syn_w_en) mem[syn_addr] = syn_wdata[7:0];
    end

    // Scoreboard and strobe-exclusion monitor
    always @(negedge clk) begin
        if (syn_r_en && syn_w_en) begin
            nerr++;
            $display("FAIL strobe_overlap: r_en=1 w_en=1, expected never both");
        end
        if (syn_w_en) begin
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", syn_addr, syn_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(syn_addr), 32'(e.addr));
                check("wr_data", syn_wdata, e.wdata);
                check("wr_sat", 32'(sat_flag), 32'(e.sat));
                check("wr_done", 32'(done_pulse), 32'd1);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ev_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!ev_ready) begin
            nerr++;
            $display("FAIL %s: ev_ready=0 after 30 cycles, expected 1", name);
        end
    endtask

    // Offer one event at a negedge, return at the negedge after the accept edge
    task automatic send(input logic [6:0] a, input logic l);
        wait_ready("send_ready");
        ev_valid = 1'b1;
        ev_addr  = a;
        ev_ltp   = l;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vt[8];
    int   acc1, acc2, nacc, r2;
    logic busy_bad;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'd0;
        syn_rdata = 8'd0;
        rst       = 1'b0;
        ev_valid  = 1'b0;
        ev_addr   = 7'd0;
        ev_ltp    = 1'b0;

        vt[0] = '{7'd13, 1'b1, 8'd100, 8'd104, 1'b0};
        vt[1] = '{7'd20, 1'b1, 8'd253, 8'd255, 1'b1};
        vt[2] = '{7'd21, 1'b1, 8'd255, 8'd255, 1'b1};
        vt[3] = '{7'd30, 1'b0, 8'd1,   8'd0,   1'b1};
        vt[4] = '{7'd31, 1'b0, 8'd40,  8'd38,  1'b0};
        vt[5] = '{7'd32, 1'b0, 8'd0,   8'd0,   1'b1};
        vt[6] = '{7'd33, 1'b1, 8'd251, 8'd255, 1'b0};
        vt[7] = '{7'd34, 1'b0, 8'd2,   8'd0,   1'b0};

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ev_ready), 32'd1);
        check("rst_r_en", 32'(syn_r_en), 32'd0);
        check("rst_w_en", 32'(syn_w_en), 32'd0);
        check("rst_addr", 32'(syn_addr), 32'd0);
        check("rst_wdata", syn_wdata, 32'd0);
        check("rst_done", 32'(done_pulse), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            mem[vt[i].addr] = vt[i].w0;
            exp_q.push_back('{vt[i].addr, {24'd0, vt[i].exp_w}, vt[i].exp_sat});
            send(vt[i].addr, vt[i].ltp);
            check("rd_strobe", 32'(syn_r_en), 32'd1);
            check("rd_addr", 32'(syn_addr), 32'(vt[i].addr));
            check("ready_busy", 32'(ev_ready), 32'd0);
            @(negedge clk);
            check("no_wr_c2", 32'(syn_w_en), 32'd0);
            @(negedge clk);
            check("no_wr_c3", 32'(syn_w_en), 32'd0);
            @(negedge clk);
            check("wr_strobe_c4", 32'(syn_w_en), 32'd1);
            @(negedge clk);
            check("done_single", 32'(done_pulse), 32'd0);
            check("wr_single", 32'(syn_w_en), 32'd0);
            check("ready_idle", 32'(ev_ready), 32'd1);
        end

        // Reset during RD_WAIT abandons the update
        mem[50] = 8'd77;
        send(7'd50, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_r_en", 32'(syn_r_en), 32'd0);
        check("mid_w_en", 32'(syn_w_en), 32'd0);
        check("mid_addr", 32'(syn_addr), 32'd0);
        check("mid_wdata", syn_wdata, 32'd0);
        check("mid_done", 32'(done_pulse), 32'd0);
        check("mid_sat", 32'(sat_flag), 32'd0);
        check("mid_ready", 32'(ev_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("post_rst_ready", 32'(ev_ready), 32'd1);
        check("post_rst_mem", 32'(mem[50]), 32'd77);

`ifndef SYN_STDP_EVBUF_EN
        // Two events held valid back-to-back
        mem[60] = 8'd10;
        mem[61] = 8'd10;
        exp_q.push_back('{7'd60, 32'd14, 1'b0});
        exp_q.push_back('{7'd61, 32'd8, 1'b0});
        acc1 = -1; acc2 = -1; nacc = 0; busy_bad = 1'b0;
        ev_valid = 1'b1;
        ev_addr  = 7'd60;
        ev_ltp   = 1'b1;
        for (int c = 0; c < 30 && nacc < 2; c++) begin
            if (acc1 >= 0 && c > acc1 && c <= acc1 + 4 && ev_ready) busy_bad = 1'b1;
            if (ev_valid && ev_ready) begin
                if (nacc == 0) acc1 = c; else acc2 = c;
                nacc++;
            end
            @(negedge clk);
            if (nacc == 1) begin
                ev_addr = 7'd61;
                ev_ltp  = 1'b0;
            end
            if (nacc == 2) ev_valid = 1'b0;
        end
        ev_valid = 1'b0;
        check("bp_accepts", 32'(nacc), 32'd2);
        check("bp_period", 32'(acc2 - acc1), 32'd5);
        check("bp_busy_ready", 32'(busy_bad), 32'd0);
        repeat (8) @(negedge clk);
`else
        // Buffered: two events on consecutive cycles
        mem[4] = 8'd10;
        mem[5] = 8'd20;
        exp_q.push_back('{7'd4, 32'd14, 1'b0});
        exp_q.push_back('{7'd5, 32'd18, 1'b0});
        wait_ready("buf_ready0");
        ev_valid = 1'b1;
        ev_addr  = 7'd4;
        ev_ltp   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("buf_rd1", 32'(syn_r_en), 32'd1);
        check("buf_ready_busy", 32'(ev_ready), 32'd1);
        ev_addr = 7'd5;
        ev_ltp  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        check("buf_full_ready", 32'(ev_ready), 32'd0);
        r2 = -1;
        for (int k = 2; k < 16; k++) begin
            if (syn_r_en && r2 < 0) begin
                r2 = k;
                check("buf_rd2_addr", 32'(syn_addr), 32'd5);
            end
            @(negedge clk);
        end
        check("buf_rd2_cycle", 32'(r2), 32'd6);
        check("buf_ready_end", 32'(ev_ready), 32'd1);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/syn_stdp_initiator.md
Name: syn_stdp_initiator

Overview:
- Master-side controller for the synapse weight memory: issues the read/write requests that the synapse block responds to.
- Accepts spike-pair events from the neuron core, reads the addressed 8-bit weight, applies a saturating STDP potentiation/depression step, and writes the result back.
- Uses the byte-lane write protocol (address = base*4 + lane).
- Sits between the spike router and the synapse instance; one initiator per synapse instance.

Parameters:
ADDR_W, 7, synapse index width (2 LSBs select byte lane, upper bits select 32-bit word)
RD_LAT, 1, cycles from syn_r_en asserted to syn_rdata valid (legal 1..7)
LTP_STEP, 8'd4, increment applied on potentiation
LTD_STEP, 8'd2, decrement applied on depression
W_MAX, 8'd255, upper saturation bound
W_MIN, 8'd0, lower saturation bound

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ev_valid  in  1  update event present
ev_ready  out  1  initiator can accept event
ev_addr  in  ADDR_W  synapse index to update
ev_ltp  in  1  1 = potentiate, 0 = depress
syn_addr  out  ADDR_W  address to synapse
syn_wdata  out  32  write data; weight in [7:0], [31:8] driven 0
syn_w_en  out  1  write strobe (single cycle)
syn_r_en  out  1  read strobe (single cycle)
syn_rdata  in  8  lane-sliced weight returned by synapse
done_pulse  out  1  one-cycle pulse when write-back issued
sat_flag  out  1  held with done_pulse; 1 if result clamped

Behaviour:
- Reset (rst=0, async): state IDLE; ev_ready=1; syn_r_en=syn_w_en=0; syn_addr=0; syn_wdata=0; done_pulse=0; sat_flag=0; RD_LAT counter=0. Reset mid-operation abandons the update with no write issued.
- Handshake: event accepted on a clk edge where ev_valid && ev_ready. ev_addr and ev_ltp are latched at that edge. ev_ready=1 only in IDLE (see Optional Feature).
- FSM:
  - IDLE: on accept -> RD_REQ.
  - RD_REQ: syn_r_en=1, syn_w_en=0, syn_addr=latched addr; -> RD_WAIT; counter loaded with RD_LAT-1.
  - RD_WAIT: strobes 0, syn_addr held. Decrement counter; when counter==0 and the cycle is RD_LAT after the RD_REQ cycle, capture syn_rdata -> CALC.
  - CALC: compute next weight into a register -> WR.
  - WR: syn_w_en=1, syn_r_en=0, syn_addr held, syn_wdata={24'b0,new_w}; done_pulse=1, sat_flag valid; -> IDLE.
- Latency: accept edge to WR cycle = RD_LAT+3 cycles. Minimum event period = RD_LAT+4 cycles.
- Arithmetic: 9-bit intermediate.
  - LTP: w+LTP_STEP, clamp to W_MAX.
  - LTD: w-LTD_STEP, clamp to W_MIN (no wrap).
  - sat_flag=1 iff a clamp was applied, including input already at bound.
- syn_r_en and syn_w_en are never high in the same cycle. That combination is reserved for the rich-club path and is never driven by this block.
- Events arriving while busy are not dropped: ev_valid is held by the source until ev_ready.

Optional Feature:
- Macro SYN_STDP_EVBUF_EN.
- Defined: one-entry event buffer.
  - ev_ready=1 whenever the buffer is empty, including while the FSM is busy.
  - A buffered event is launched from IDLE on the cycle after WR, giving a back-to-back period of RD_LAT+4 with no handshake gap.
  - Simultaneous accept and launch in IDLE bypasses the buffer.
  - Reset clears the buffer.
- Undefined: ev_ready=1 only in IDLE; no buffer logic.

Decomposition:
- Shared package syn_pkg:
  - state enum (IDLE, RD_REQ, RD_WAIT, CALC, WR)
  - lane/base split constants (LANE_W=2)
  - weight width constant WGT_W=8
- Sub-module syn_stdp_sat_alu: combinational saturating add/sub producing new_w and sat. Instantiated once.
- FSM, latency counter and optional buffer stay in the top module.

Test Plan:
- Each scenario uses a behavioural synapse model with RD_LAT=1.
- LTP basic: ev_addr=7'd13, ev_ltp=1, model weight 100. Expect syn_r_en at addr 13 one cycle after accept; syn_w_en with syn_wdata=32'd104 on accept+4; done_pulse=1, sat_flag=0.
- LTP saturation: weight 253, ev_ltp=1. Expect write of 255, sat_flag=1. With weight 255 the write is also 255, sat_flag=1.
- LTD floor: weight 1, ev_ltp=0. Expect write 0, sat_flag=1. With weight 40 the write is 38, sat_flag=0.
- Busy backpressure (macro off): two events held valid back-to-back. Expect ev_ready=0 from accept to WR; second accept on the cycle after WR; strobes never overlap.
- Reset mid-op: deassert rst during RD_WAIT. Expect all outputs zero immediately, no syn_w_en, ev_ready=1 after release.
- Buffer (SYN_STDP_EVBUF_EN defined): events to addr 4 and 5 offered on consecutive cycles. Expect both accepted without stall; second syn_r_en on the cycle after the first WR.
